// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the register-0 suppression predicate
// for the regfile_sb core and its scoreboard.
package regfile_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned DEF_NRD  = 2;

    // True when an access to this address must be ignored because register 0
    // is hardwired to zero.
    function automatic logic is_zero_suppressed(input logic zero_reg, input logic addr_is_zero);
        return zero_reg & addr_is_zero;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bit per register with set/clear/flush
// priority, plus a per-read-port lookup of the bit after this cycle's
// write-clear and flush (this cycle's set deliberately excluded).
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_clr, i_clr_addr qualified register write clears its bit
//   i_set, i_set_addr reserve a destination (mark busy)
//   i_flush           clear every bit, overrides set
//   i_rd_addr         NRD packed read addresses
//   o_rd_busy_c       combinational busy-after-clear per read port
//   o_busy_vec        registered scoreboard state
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = DEF_NREG,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic              i_set,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_flush,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy_c,
    output logic [NREG-1:0]   o_busy_vec
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] sb_kept;

    // Next-state: clear then set (set wins on collision), flush beats both.
    always_comb begin
        clr_mask    = '0;
        set_mask    = '0;
        o_rd_busy_c = '0;
        if (i_clr) begin
            clr_mask[i_clr_addr] = 1'b1;
        end
        if (i_set && !is_zero_suppressed(ZERO_REG, i_set_addr == '0)) begin
            set_mask[i_set_addr] = 1'b1;
        end
        sb_kept = i_flush ? '0 : (sb_q & ~clr_mask);
        sb_d    = i_flush ? '0 : (sb_kept | set_mask);
        // Readers see the state without this cycle's set, so an instruction
        // reserving its own source does not block on itself.
        for (int unsigned p = 0; p < NRD; p++) begin
            o_rd_busy_c[p] = sb_kept[i_rd_addr[p*AW +: AW]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign o_busy_vec = sb_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with NRD registered read ports,
// same-edge write-through bypass and an integrated pending-write scoreboard.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_rd_en, i_rd_addr  per-port read enable / packed addresses
//   o_rd_data           packed registered read data (port p at [p*XLEN +: XLEN])
//   o_rd_busy           registered per-port pending-write flag
//   i_we, i_wa, i_wd    register write
//   i_sb_set, i_sb_addr reserve a destination in the scoreboard
//   i_flush             clear the whole scoreboard
//   o_busy_vec          registered scoreboard state
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned NREG     = DEF_NREG,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    // Derived from NREG; do not override.
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD-1:0]      i_rd_en,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_we,
    input  logic [AW-1:0]       i_wa,
    input  logic [XLEN-1:0]     i_wd,
    input  logic                i_sb_set,
    input  logic [AW-1:0]       i_sb_addr,
    input  logic                i_flush,
    output logic [NREG-1:0]     o_busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            we_ok_c;
    logic [NRD-1:0]  rd_busy_c;

    // A write to register 0 is dropped entirely when it is hardwired.
    assign we_ok_c = i_we & ~is_zero_suppressed(ZERO_REG, i_wa == '0);

    // Data array.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_ok_c) begin
            regs_q[i_wa] <= i_wd;
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (we_ok_c),
        .i_clr_addr  (i_wa),
        .i_set       (i_sb_set),
        .i_set_addr  (i_sb_addr),
        .i_flush     (i_flush),
        .i_rd_addr   (i_rd_addr),
        .o_rd_busy_c (rd_busy_c),
        .o_busy_vec  (o_busy_vec)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr_c;
        logic [XLEN-1:0] data_d;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign addr_c = i_rd_addr[p*AW +: AW];

        // Read mux: zero register, then same-edge bypass, then array.
        always_comb begin
            data_d = regs_q[addr_c];
            if (is_zero_suppressed(ZERO_REG, addr_c == '0)) begin
                data_d = '0;
            end else if (we_ok_c && (i_wa == addr_c)) begin
                data_d = i_wd;
            end
        end

        // Output registers hold while the port is idle.
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (i_rd_en[p]) begin
                data_q <= data_d;
                busy_q <= rd_busy_c[p];
            end
        end

        assign o_rd_data[p*XLEN +: XLEN] = data_q;
        assign o_rd_busy[p]              = busy_q;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with synchronous multi-port reads, write-through bypass and an integrated pending-write scoreboard. It sits in the decode stage of the pipelined core and replaces the fixed 2-read, 32×32 register file. Decode gets operand data and per-operand "still pending" flags in the same registered cycle, so hazard logic no longer needs its own busy table. Reads and writes all occur on the rising edge of i_clk; there is no falling-edge write.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, register 0 reads as 0, ignores writes, is never marked busy
- AW, $clog2(NREG), address width; derived, not overridden

Ports:
- i_clk  in  1  clock, all state updates on the rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_rd_en  in  NRD  per-port read enable
- i_rd_addr  in  NRD×AW  per-port read address
- o_rd_data  out  NRD×XLEN  registered read data
- o_rd_busy  out  NRD  registered flag: the read register has an outstanding write
- i_we  in  1  write enable
- i_wa  in  AW  write address
- i_wd  in  XLEN  write data
- i_sb_set  in  1  reserve a destination, i.e. mark it busy at issue
- i_sb_addr  in  AW  register to reserve
- i_flush  in  1  clear all scoreboard bits (pipeline flush)
- o_busy_vec  out  NREG  current scoreboard state, registered

## Operation
- Storage: NREG×XLEN array and NREG-bit scoreboard `sb`.
- Write: on an edge with i_we=1, set regs[i_wa] ← i_wd. If ZERO_REG=1 and i_wa=0, there is no effect.
- Scoreboard clear: a write also clears sb[i_wa].
- Scoreboard set: on an edge with i_sb_set=1, set sb[i_sb_addr] ← 1. This is suppressed for address 0 when ZERO_REG=1.
- Set/clear collision: set and write-clear to the same address in the same cycle → set wins and the bit stays 1. A new producer has been issued.
- Flush: i_flush=1 clears every sb bit. It overrides set in the same cycle. Register writes still commit.
- Read port p, with i_rd_en[p]=1 on an edge:
  - o_rd_data[p] ← i_wd if i_we and i_wa==i_rd_addr[p] and the write is not suppressed (write-through bypass); otherwise regs[i_rd_addr[p]].
  - Address 0 with ZERO_REG=1 → 0.
  - o_rd_busy[p] ← sb[addr] after this cycle's write-clear and flush, ignoring this cycle's set. An instruction reserving its own source is not self-blocked.
- Read port p with i_rd_en[p]=0: o_rd_data[p] and o_rd_busy[p] hold their previous values.
- Ports are independent. Any number of ports may read the same address.
- o_busy_vec is the sb register itself.

## Timing
- Read latency: 1 cycle from address to o_rd_data/o_rd_busy.
- Write-to-read: 0 cycles. A write and a read of the same address on the same edge return the new data.
- Scoreboard set is visible on o_busy_vec 1 cycle later. On o_rd_busy it is visible for reads sampled on the following edge.
- Reset (i_rst=0 at an edge) sets all of the following to 0: every regs entry, sb, o_busy_vec, o_rd_data, o_rd_busy. Reset overrides writes, sets and reads in that cycle. Reset mid-operation discards any pending state.
- No backpressure or handshake. All inputs are sampled every edge.

## Structure
- Package `regfile_pkg`: default XLEN/NREG constants and a helper function for the ZERO_REG suppression predicate. Core modules share it.
- Sub-module `regfile_scoreboard`: sb register with set/clear/flush priority, o_busy_vec, and a combinational "busy after clear" lookup per read port.
- Top module: data array, bypass muxes, output registers, instantiated in a generate loop over NRD.

## Test plan
- Reset then read all 32 regs on 2 ports → every o_rd_data=0, o_busy_vec=0.
- Write x5=0xDEADBEEF; next cycle read x5 → 0xDEADBEEF. Same-edge write x7=0x1234 with read x7 → o_rd_data=0x1234 one cycle later.
- Write x0=0xFFFFFFFF, i_sb_set addr 0 → read x0=0, o_busy_vec[0]=0.
- Set x3 busy; next cycle read x3 → o_rd_busy=1. Write x3=0x55 alongside the read → o_rd_busy=0, data 0x55. Simultaneous set and write x3 → o_busy_vec[3] stays 1.
- Set x1,x2,x9 busy, then pulse i_flush together with set x4 → o_busy_vec=0. The flushed write to x2 still lands.
- NRD=3, NREG=16, XLEN=64: three ports read the same and different addresses; i_rd_en deasserted holds old data. Assert reset mid-sequence → all outputs 0 on the next cycle.
